// File: rtl/tl_a_channel_arbiter_if.sv
// Bus bundle for the two-master A/D channel arbiter.
// The "slave" modport is the arbiter's own view; "master" is the
// surrounding environment (both load/store masters plus the shared slave).
interface tl_a_channel_arbiter_if #(
    parameter int A_W = 55,
    parameter int D_W = 47
);
    logic [A_W-1:0] m0_a_channel;
    logic [A_W-1:0] m1_a_channel;
    logic [D_W-1:0] m0_d_channel;
    logic [D_W-1:0] m1_d_channel;
    logic [A_W-1:0] s_a_channel;
    logic [D_W-1:0] s_d_channel;
    logic [1:0]     m_drop;
    logic           stray_resp;
    logic           busy;

    modport slave (
        input  m0_a_channel,
        input  m1_a_channel,
        input  s_d_channel,
        output m0_d_channel,
        output m1_d_channel,
        output s_a_channel,
        output m_drop,
        output stray_resp,
        output busy
    );

    modport master (
        output m0_a_channel,
        output m1_a_channel,
        output s_d_channel,
        input  m0_d_channel,
        input  m1_d_channel,
        input  s_a_channel,
        input  m_drop,
        input  stray_resp,
        input  busy
    );
endinterface

// File: rtl/tl_a_channel_arbiter.sv
// Shares one TileLink-style slave between two load/store masters.
// Each master's one-cycle request pulse is parked in a single holding slot;
// an IDLE/ISSUE/WAIT FSM picks a slot round-robin, sends it to the slave with
// the source field rewritten to the master index, and routes the matching D
// response back with the original source restored. If the slave stays silent
// for TIMEOUT wait cycles, an error response is synthesised instead.
// Only one transaction is ever outstanding at the slave.
module tl_a_channel_arbiter #(
    parameter int A_W     = 55,
    parameter int D_W     = 47,
    parameter int TIMEOUT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    tl_a_channel_arbiter_if.slave bus
);

    // A channel field positions
    localparam int A_OP_LO   = 52;
    localparam int A_SIZE_LO = 46;
    localparam int A_SRC_LO  = 44;
    localparam int A_VALID   = 1;

    // D channel field positions
    localparam int D_OP_LO   = 44;
    localparam int D_SIZE_LO = 37;
    localparam int D_SRC_LO  = 35;
    localparam int D_ERR     = 34;
    localparam int D_VALID   = 1;
    localparam int D_READY   = 0;

    // Opcodes involved in the synthesised error response
    localparam logic [2:0] OP_GET             = 3'd4;
    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Last WAIT cycle in which a response is still accepted
    localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT - 1);

    // Per-master views, gathered from the generate block below
    logic [A_W-1:0] a_in  [2];
    logic [A_W-1:0] hold  [2];
    logic [D_W-1:1] d_out [2];
    logic [1:0]     pend;
    logic [1:0]     drop;

    // FSM and datapath state
    logic [1:0]     state_reg,      state_next;
    logic           grant_reg,      grant_next;
    logic           last_grant_reg, last_grant_next;
    logic [3:0]     timer_reg,      timer_next;
    logic [1:0]     orig_src_reg,   orig_src_next;
    logic [A_W-1:0] s_a_reg,        s_a_next;
    logic           stray_reg,      stray_next;

    // Response hand-off from the FSM to the per-master D registers
    logic           resp_load;
    logic [D_W-1:1] resp_word;
    logic [1:0]     done;

    // Decoded helpers
    logic           d_valid;
    logic           d_match;
    logic           timer_expired;
    logic           pick;
    logic [2:0]     granted_op;
    logic [2:0]     granted_size;

    assign a_in[0] = bus.m0_a_channel;
    assign a_in[1] = bus.m1_a_channel;

    assign d_valid       = bus.s_d_channel[D_VALID];
    assign d_match       = (bus.s_d_channel[D_SRC_LO +: 2] == {1'b0, grant_reg});
    assign timer_expired = (timer_reg == TIMER_LAST);

    // Round-robin choice: the first pending slot after the last one served.
    // With only two masters this reduces to "the other one if it is pending".
    assign pick = last_grant_reg ? ~pend[0] : pend[1];

    // The granted slot stays frozen while its pend bit is set, so its op and
    // size can be read directly when building a timeout response.
    assign granted_op   = hold[grant_reg][A_OP_LO +: 3];
    assign granted_size = hold[grant_reg][A_SIZE_LO +: 3];

    // FSM next-state, slave request word and response construction
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        timer_next      = timer_reg;
        orig_src_next   = orig_src_reg;
        s_a_next        = s_a_reg;
        s_a_next[A_VALID] = 1'b0;
        stray_next      = 1'b0;
        resp_load       = 1'b0;
        resp_word       = '0;
        done            = 2'b00;

        case (state_reg)
            ST_IDLE: begin
                // Nothing is outstanding, so any slave response is unexpected
                stray_next = d_valid;
                if (pend != 2'b00) begin
                    // The request word is registered here so that it is on
                    // the slave bus, valid, for exactly the ISSUE cycle.
                    grant_next          = pick;
                    s_a_next            = hold[pick];
                    s_a_next[A_SRC_LO +: 2] = {1'b0, pick};
                    s_a_next[A_VALID]   = 1'b1;
                    orig_src_next       = hold[pick][A_SRC_LO +: 2];
                    state_next          = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // The slave cannot legitimately answer a request it is only
                // now seeing.
                stray_next = d_valid;
                timer_next = 4'd0;
                state_next = ST_WAIT;
            end

            ST_WAIT: begin
                if (d_valid && d_match) begin
                    // Forward the slave word, restoring the master's source
                    resp_load = 1'b1;
                    resp_word = bus.s_d_channel[D_W-1:1];
                    resp_word[D_SRC_LO +: 2] = orig_src_reg;
                    resp_word[D_VALID]       = 1'b1;
                    done[grant_reg]   = 1'b1;
                    last_grant_next   = grant_reg;
                    state_next        = ST_IDLE;
                end else begin
                    // A response for the wrong source does not stop the clock
                    stray_next = d_valid;
                    if (timer_expired) begin
                        resp_load = 1'b1;
                        resp_word[D_OP_LO +: 3]   = (granted_op == OP_GET) ? OP_ACCESS_ACK_DATA
                                                                           : OP_ACCESS_ACK;
                        resp_word[D_SIZE_LO +: 5] = {2'b00, granted_size};
                        resp_word[D_SRC_LO +: 2]  = orig_src_reg;
                        resp_word[D_ERR]          = 1'b1;
                        resp_word[D_VALID]        = 1'b1;
                        done[grant_reg]   = 1'b1;
                        last_grant_next   = grant_reg;
                        state_next        = ST_IDLE;
                    end else begin
                        timer_next = timer_reg + 4'd1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM and slave-side registers; master 0 wins the first tie after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            timer_reg      <= 4'd0;
            orig_src_reg   <= 2'd0;
            s_a_reg        <= '0;
            stray_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            timer_reg      <= timer_next;
            orig_src_reg   <= orig_src_next;
            s_a_reg        <= s_a_next;
            stray_reg      <= stray_next;
        end
    end

    // Per-master holding slot, drop flag and response register
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            logic [A_W-1:0] hold_reg;
            logic           pend_reg;
            logic           drop_reg;
            logic [D_W-1:1] d_reg;
            logic           load_here;

            assign load_here = resp_load && (grant_reg == 1'(gi));

            // Capture runs regardless of FSM state; a slot being released on
            // this edge is free to accept a new request on the same edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    hold_reg <= '0;
                    pend_reg <= 1'b0;
                    drop_reg <= 1'b0;
                end else begin
                    drop_reg <= 1'b0;
                    if (a_in[gi][A_VALID]) begin
                        if (!pend_reg || done[gi]) begin
                            hold_reg <= a_in[gi];
                            pend_reg <= 1'b1;
                        end else begin
                            drop_reg <= 1'b1;
                        end
                    end else if (done[gi]) begin
                        pend_reg <= 1'b0;
                    end
                end
            end

            // Response register: valid is a one-cycle pulse, other bits hold
            always_ff @(posedge clk) begin
                if (reset) begin
                    d_reg <= '0;
                end else if (load_here) begin
                    d_reg <= resp_word;
                end else begin
                    d_reg[D_VALID] <= 1'b0;
                end
            end

            assign hold[gi]  = hold_reg;
            assign pend[gi]  = pend_reg;
            assign drop[gi]  = drop_reg;
            assign d_out[gi] = d_reg;
        end
    endgenerate

    // Ready is a straight pass-through from the slave to both masters
    assign bus.m0_d_channel = {d_out[0], bus.s_d_channel[D_READY]};
    assign bus.m1_d_channel = {d_out[1], bus.s_d_channel[D_READY]};
    assign bus.s_a_channel  = s_a_reg;
    assign bus.m_drop       = drop;
    assign bus.stray_resp   = stray_reg;
    assign bus.busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_tl_a_channel_arbiter.sv
// Self-checking bench for tl_a_channel_arbiter: directed scenarios plus a
// randomized run, all compared against transaction-level expectations.
module tb_tl_a_channel_arbiter;
    localparam int A_W     = 55;
    localparam int D_W     = 47;
    localparam int TIMEOUT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    // Transaction-level model state: index of the master served last
    int model_last = 1;

    // Event counters observed on the falling edge
    int sa_count    = 0;
    int drop0_count = 0;

    always #5 clk = ~clk;

    tl_a_channel_arbiter_if #(.A_W(A_W), .D_W(D_W)) bus ();

    tl_a_channel_arbiter #(.A_W(A_W), .D_W(D_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(negedge clk) begin
        if (bus.s_a_channel[1]) sa_count++;
        if (bus.m_drop[0])      drop0_count++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- helpers: stimulus and expectations ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [A_W-1:0] mk_a(input logic [2:0] op, input logic [1:0] src,
                                            input logic [9:0] addr, input logic [31:0] data);
        logic [A_W-1:0] w;
        w        = '0;
        w[54:52] = op;
        w[51:49] = 3'($urandom_range(0, 7));
        w[48:46] = 3'($urandom_range(0, 7));
        w[45:44] = src;
        w[43:34] = addr;
        w[33:2]  = data;
        w[1]     = 1'b1;
        w[0]     = 1'($urandom_range(0, 1));
        return w;
    endfunction

    function automatic logic [D_W-1:0] mk_d(input logic [2:0] op, input logic [1:0] src,
                                            input logic err, input logic [31:0] data);
        logic [D_W-1:0] d;
        d        = '0;
        d[46:44] = op;
        d[43:42] = 2'($urandom_range(0, 3));
        d[41:37] = 5'($urandom_range(0, 31));
        d[36:35] = src;
        d[34]    = err;
        d[33:2]  = data;
        d[1]     = 1'b1;
        return d;
    endfunction

    // Slave request: master word, source replaced by the master index, valid
    function automatic logic [A_W-1:0] exp_s_a(input logic [A_W-1:0] w, input int m);
        logic [A_W-1:0] r;
        r        = w;
        r[45:44] = 2'(m);
        r[1]     = 1'b1;
        return r;
    endfunction

    // Forwarded response: slave word with the master's own source restored
    function automatic logic [D_W-1:0] exp_fwd(input logic [D_W-1:0] resp, input logic [1:0] src);
        logic [D_W-1:0] r;
        r        = resp;
        r[36:35] = src;
        r[1]     = 1'b1;
        return r;
    endfunction

    // Timeout response built from the original request
    function automatic logic [D_W-1:0] exp_err(input logic [A_W-1:0] w);
        logic [D_W-1:0] r;
        r        = '0;
        r[46:44] = (w[54:52] == 3'd4) ? 3'd1 : 3'd0;
        r[41:37] = {2'b00, w[48:46]};
        r[36:35] = w[45:44];
        r[34]    = 1'b1;
        r[1]     = 1'b1;
        return r;
    endfunction

    function automatic logic [D_W-1:0] md_of(input int m);
        return (m == 0) ? bus.m0_d_channel : bus.m1_d_channel;
    endfunction

    function automatic logic [2:0] rand_op();
        return ($urandom_range(0, 1) == 0) ? 3'd4 : 3'($urandom_range(0, 1));
    endfunction

    task automatic pulse(input logic [1:0] mask, input logic [A_W-1:0] w0, input logic [A_W-1:0] w1);
        bus.m0_a_channel = mask[0] ? w0 : '0;
        bus.m1_a_channel = mask[1] ? w1 : '0;
        tick();
        bus.m0_a_channel = '0;
        bus.m1_a_channel = '0;
    endtask

    task automatic wait_issue(output logic ok, output logic [A_W-1:0] sa, output int n);
        ok = 1'b0;
        sa = '0;
        n  = 0;
        while (n < 10 && !ok) begin
            tick();
            n++;
            if (bus.s_a_channel[1]) begin
                ok = 1'b1;
                sa = bus.s_a_channel;
            end
        end
    endtask

    // Starting in the cycle where s_a is valid: optionally answer in WAIT
    // cycle d, then wait for master m's response pulse (bounded).
    task automatic serve(input int m, input bit respond, input int d, input logic [D_W-1:0] resp,
                         output logic ok, output logic [D_W-1:0] md, output int n, output logic other);
        logic [D_W-1:0] cur;
        logic [D_W-1:0] oth;
        ok    = 1'b0;
        md    = '0;
        n     = 0;
        other = 1'b0;
        while (n < 20 && !ok) begin
            bus.s_d_channel = (respond && n == d + 1) ? resp : '0;
            tick();
            n++;
            cur = md_of(m);
            oth = md_of(1 - m);
            if (oth[1]) other = 1'b1;
            if (cur[1]) begin
                ok = 1'b1;
                md = cur;
            end
        end
        bus.s_d_channel = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.m0_a_channel = '0;
        bus.m1_a_channel = '0;
        bus.s_d_channel  = '0;
        repeat (2) tick();
        reset = 1'b0;
        model_last = 1;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.m0_a_channel = mk_a(3'd4, 2'd1, 10'h3A, 32'h0);
        bus.m1_a_channel = mk_a(3'd0, 2'd2, 10'h11, 32'h5);
        bus.s_d_channel  = mk_d(3'd1, 2'd0, 1'b0, 32'h1);
        repeat (3) tick();
        tests_run++;
        if (bus.s_a_channel !== '0) begin
            tests_failed++;
            $display("FAIL reset_s_a: got %h expected 0", bus.s_a_channel);
        end
        tests_run++;
        if (bus.m0_d_channel !== '0 || bus.m1_d_channel !== '0) begin
            tests_failed++;
            $display("FAIL reset_m_d: got m0 %h m1 %h expected 0", bus.m0_d_channel, bus.m1_d_channel);
        end
        tests_run++;
        if ({bus.m_drop, bus.stray_resp, bus.busy} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got drop %b stray %b busy %b expected 0",
                     bus.m_drop, bus.stray_resp, bus.busy);
        end
        bus.m0_a_channel = '0;
        bus.m1_a_channel = '0;
        bus.s_d_channel  = '0;
        reset = 1'b0;
        model_last = 1;
        repeat (2) tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.s_a_channel[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got busy %b s_a valid %b expected 0 0", bus.busy, bus.s_a_channel[1]);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_single_get();
        logic [A_W-1:0] w, sa;
        logic [D_W-1:0] resp, md, ex;
        logic ok, other;
        int n;
        w = mk_a(3'd4, 2'd1, 10'h03A, 32'h0);
        pulse(2'b01, w, '0);
        wait_issue(ok, sa, n);
        tests_run++;
        if (ok !== 1'b1 || n != 1) begin
            tests_failed++;
            $display("FAIL get_issue_latency: got ok %b after %0d cycles expected 1 after 1", ok, n);
        end
        tests_run++;
        if (sa !== exp_s_a(w, 0)) begin
            tests_failed++;
            $display("FAIL get_s_a: got %h expected %h", sa, exp_s_a(w, 0));
        end
        resp = mk_d(3'd1, 2'd0, 1'b0, 32'hDEADBEEF);
        serve(0, 1'b1, 0, resp, ok, md, n, other);
        ex = exp_fwd(resp, 2'd1);
        tests_run++;
        if (ok !== 1'b1 || n != 2) begin
            tests_failed++;
            $display("FAIL get_resp_latency: got ok %b after %0d cycles expected 1 after 2", ok, n);
        end
        tests_run++;
        if (md[D_W-1:1] !== ex[D_W-1:1] || other !== 1'b0) begin
            tests_failed++;
            $display("FAIL get_m0_d: got %h other %b expected %h other 0", md, other, ex);
        end
        tick();
        tests_run++;
        if (bus.m0_d_channel[1] !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL get_after: got valid %b busy %b expected 0 0", bus.m0_d_channel[1], bus.busy);
        end
        bus.s_d_channel = '0;
        bus.s_d_channel[0] = 1'b1;
        #1;
        tests_run++;
        if (bus.m0_d_channel[0] !== 1'b1 || bus.m1_d_channel[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_pass: got m0 %b m1 %b expected 1 1", bus.m0_d_channel[0], bus.m1_d_channel[0]);
        end
        bus.s_d_channel = '0;
        model_last = 0;
        $display("[TB] single get: data %h", md[33:2]);
    endtask

    task automatic test_round_robin();
        logic [A_W-1:0] w0, w1, wexp, sa;
        logic [D_W-1:0] resp, md, ex;
        logic ok, other;
        int n, d, first, m;
        do_reset();
        for (int round = 0; round < 2; round++) begin
            w0 = mk_a(rand_op(), 2'($urandom_range(0, 3)), 10'($urandom), $urandom);
            w1 = mk_a(rand_op(), 2'($urandom_range(0, 3)), 10'($urandom), $urandom);
            pulse(2'b11, w0, w1);
            first = (model_last == 1) ? 0 : 1;
            for (int k = 0; k < 2; k++) begin
                m    = (k == 0) ? first : 1 - first;
                wexp = (m == 0) ? w0 : w1;
                wait_issue(ok, sa, n);
                tests_run++;
                if (ok !== 1'b1 || sa !== exp_s_a(wexp, m)) begin
                    tests_failed++;
                    $display("FAIL rr_order r%0d k%0d: got %h expected %h", round, k, sa, exp_s_a(wexp, m));
                end
                d    = $urandom_range(0, TIMEOUT - 1);
                resp = mk_d(3'($urandom_range(0, 1)), 2'(m), 1'b0, $urandom);
                serve(m, 1'b1, d, resp, ok, md, n, other);
                ex = exp_fwd(resp, wexp[45:44]);
                tests_run++;
                if (ok !== 1'b1 || n != d + 2 || md[D_W-1:1] !== ex[D_W-1:1] || other !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rr_resp r%0d k%0d: got %h in %0d other %b expected %h in %0d",
                             round, k, md, n, other, ex, d + 2);
                end
                model_last = m;
                $display("[TB] round robin pair %0d: served master %0d", round, m);
            end
        end
    endtask

    task automatic test_timeout();
        logic [A_W-1:0] w, sa;
        logic [D_W-1:0] md, ex;
        logic ok, other;
        int n;
        w = mk_a(3'd0, 2'($urandom_range(0, 3)), 10'h155, 32'h12345678);
        pulse(2'b10, '0, w);
        wait_issue(ok, sa, n);
        tests_run++;
        if (ok !== 1'b1 || sa !== exp_s_a(w, 1)) begin
            tests_failed++;
            $display("FAIL to_s_a: got %h expected %h", sa, exp_s_a(w, 1));
        end
        serve(1, 1'b0, 0, '0, ok, md, n, other);
        ex = exp_err(w);
        tests_run++;
        if (ok !== 1'b1 || n != TIMEOUT + 1) begin
            tests_failed++;
            $display("FAIL to_latency: got ok %b after %0d expected after %0d", ok, n, TIMEOUT + 1);
        end
        tests_run++;
        if (md[D_W-1:1] !== ex[D_W-1:1] || other !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_resp: got %h busy %b expected %h busy 0", md, bus.busy, ex);
        end
        sa_count = 0;
        repeat (4) tick();
        tests_run++;
        if (sa_count != 0) begin
            tests_failed++;
            $display("FAIL to_pend_clear: got %0d reissues expected 0", sa_count);
        end
        model_last = 1;
        $display("[TB] timeout: error response %h", md);
    endtask

    task automatic test_drop();
        logic [A_W-1:0] w, w2;
        logic [D_W-1:0] resp, md, ex;
        logic ok, other;
        int n;
        sa_count    = 0;
        drop0_count = 0;
        w  = mk_a(3'd4, 2'd2, 10'h2A, 32'h0);
        w2 = mk_a(3'd0, 2'd3, 10'h3F, 32'hCAFEF00D);
        pulse(2'b01, w, '0);
        pulse(2'b01, w2, '0);
        tests_run++;
        if (bus.m_drop !== 2'b01) begin
            tests_failed++;
            $display("FAIL drop_flag: got %b expected 01", bus.m_drop);
        end
        tests_run++;
        if (bus.s_a_channel !== exp_s_a(w, 0)) begin
            tests_failed++;
            $display("FAIL drop_kept: got %h expected %h", bus.s_a_channel, exp_s_a(w, 0));
        end
        resp = mk_d(3'd1, 2'd0, 1'b0, $urandom);
        serve(0, 1'b1, 0, resp, ok, md, n, other);
        ex = exp_fwd(resp, 2'd2);
        tests_run++;
        if (ok !== 1'b1 || md[D_W-1:1] !== ex[D_W-1:1]) begin
            tests_failed++;
            $display("FAIL drop_resp: got %h expected %h", md, ex);
        end
        repeat (4) tick();
        tests_run++;
        if (sa_count != 1 || drop0_count != 1) begin
            tests_failed++;
            $display("FAIL drop_counts: got %0d issues %0d drops expected 1 1", sa_count, drop0_count);
        end
        model_last = 0;
        $display("[TB] drop: issues %0d drops %0d", sa_count, drop0_count);
    endtask

    task automatic test_stray();
        logic [A_W-1:0] w, sa;
        logic [D_W-1:0] resp, ex;
        logic ok;
        int n;
        do_reset();
        w = mk_a(3'd4, 2'd3, 10'h0F0, 32'h0);
        pulse(2'b01, w, '0);
        wait_issue(ok, sa, n);
        tick();
        bus.s_d_channel = mk_d(3'd1, 2'd1, 1'b0, $urandom);
        tick();
        bus.s_d_channel = '0;
        tests_run++;
        if (bus.stray_resp !== 1'b1 || bus.m0_d_channel[1] !== 1'b0 || bus.m1_d_channel[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_wrong_src: got stray %b m0 %b m1 %b expected 1 0 0",
                     bus.stray_resp, bus.m0_d_channel[1], bus.m1_d_channel[1]);
        end
        resp = mk_d(3'd1, 2'd0, 1'b0, $urandom);
        bus.s_d_channel = resp;
        tick();
        bus.s_d_channel = '0;
        ex = exp_fwd(resp, 2'd3);
        tests_run++;
        if (bus.m0_d_channel[D_W-1:1] !== ex[D_W-1:1] || bus.stray_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_then_match: got %h stray %b expected %h stray 0",
                     bus.m0_d_channel, bus.stray_resp, ex);
        end
        model_last = 0;
        $display("[TB] stray: forwarded %h", bus.m0_d_channel);
    endtask

    task automatic test_reset_mid();
        logic [A_W-1:0] w, sa;
        logic ok;
        int n;
        w = mk_a(3'd4, 2'd0, 10'h100, 32'h0);
        pulse(2'b10, '0, w);
        wait_issue(ok, sa, n);
        tick();
        reset = 1'b1;
        tick();
        tests_run++;
        if (bus.s_a_channel !== '0 || bus.m0_d_channel !== '0 || bus.m1_d_channel !== '0 ||
            bus.m_drop !== 2'b00 || bus.stray_resp !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got s_a %h m1_d %h busy %b expected all 0",
                     bus.s_a_channel, bus.m1_d_channel, bus.busy);
        end
        reset = 1'b0;
        bus.s_d_channel = mk_d(3'd1, 2'd1, 1'b0, $urandom);
        tick();
        bus.s_d_channel = '0;
        tests_run++;
        if (bus.stray_resp !== 1'b1 || bus.m0_d_channel[1] !== 1'b0 || bus.m1_d_channel[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_late: got stray %b m0 %b m1 %b expected 1 0 0",
                     bus.stray_resp, bus.m0_d_channel[1], bus.m1_d_channel[1]);
        end
        tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.s_a_channel[1] !== 1'b0 || bus.stray_resp !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_idle: got busy %b s_a valid %b stray %b expected 0 0 0",
                     bus.busy, bus.s_a_channel[1], bus.stray_resp);
        end
        model_last = 1;
        $display("[TB] reset mid-transaction handled");
    endtask

    task automatic test_random();
        logic [A_W-1:0] w0, w1, wexp, sa;
        logic [D_W-1:0] resp, md, ex;
        logic [1:0] mask;
        logic ok, other;
        bit respond;
        int n, d, cnt, first, m, exp_n;
        for (int it = 0; it < 16; it++) begin
            mask = 2'($urandom_range(1, 3));
            w0 = mk_a(rand_op(), 2'($urandom_range(0, 3)), 10'($urandom), $urandom);
            w1 = mk_a(rand_op(), 2'($urandom_range(0, 3)), 10'($urandom), $urandom);
            pulse(mask, w0, w1);
            if (mask == 2'b11) begin
                cnt   = 2;
                first = (model_last == 1) ? 0 : 1;
            end else begin
                cnt   = 1;
                first = (mask == 2'b01) ? 0 : 1;
            end
            for (int k = 0; k < cnt; k++) begin
                m    = (k == 0) ? first : 1 - first;
                wexp = (m == 0) ? w0 : w1;
                wait_issue(ok, sa, n);
                tests_run++;
                if (ok !== 1'b1 || sa !== exp_s_a(wexp, m)) begin
                    tests_failed++;
                    $display("FAIL rand_s_a it%0d: got %h expected %h", it, sa, exp_s_a(wexp, m));
                end
                respond = ($urandom_range(0, 3) != 0);
                d       = $urandom_range(0, TIMEOUT - 1);
                resp    = mk_d(3'($urandom_range(0, 7)), 2'(m), 1'($urandom_range(0, 1)), $urandom);
                serve(m, respond, d, resp, ok, md, n, other);
                ex    = respond ? exp_fwd(resp, wexp[45:44]) : exp_err(wexp);
                exp_n = respond ? d + 2 : TIMEOUT + 1;
                tests_run++;
                if (ok !== 1'b1 || n != exp_n || md[D_W-1:1] !== ex[D_W-1:1] || other !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rand_resp it%0d: got %h in %0d other %b expected %h in %0d",
                             it, md, n, other, ex, exp_n);
                end
                model_last = m;
                $display("[TB] random %0d: master %0d %s", it, m, respond ? "answered" : "timed out");
            end
        end
    endtask

    initial begin
        bus.m0_a_channel = '0;
        bus.m1_a_channel = '0;
        bus.s_d_channel  = '0;
        test_reset();
        test_single_get();
        test_round_robin();
        test_timeout();
        test_drop();
        test_stray();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
